exe_mem_wb_backend: RTL and testbench



---
 rtl/exe_mem_wb_backend.sv | 159 +++++++++++++++
 tb/tb_exe_mem_wb_backend.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_mem_wb_backend.sv
// exe_mem_wb_backend
// Back half of the five-stage pipeline. It executes the ALU operation,
// holds the EXE/MEM and MEM/WB pipeline registers and the word-addressed
// data memory, and drives the register-file write-back triple. The EXE
// result and the EXE/MEM control are exported as forwarding taps.
module exe_mem_wb_backend #(
    parameter int DMEM_AW = 5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic        ealuimm,
    input  logic [3:0]  ealuc,
    input  logic [4:0]  edestReg,
    input  logic [31:0] eqa,
    input  logic [31:0] eqb,
    input  logic [31:0] eimm32,
    output logic [31:0] ealu,
    output logic        mwreg,
    output logic        mm2reg,
    output logic [4:0]  mdestReg,
    output logic [31:0] malu,
    output logic        wwreg,
    output logic [4:0]  wdestReg,
    output logic [31:0] wbData
);

    localparam int DMEM_DEPTH = 1 << DMEM_AW;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // EXE/MEM pipeline register
    logic        mwreg_q,    mwreg_d;
    logic        mm2reg_q,   mm2reg_d;
    logic        mwmem_q,    mwmem_d;
    logic [4:0]  mdest_q,    mdest_d;
    logic [31:0] malu_q,     malu_d;
    logic [31:0] mqb_q,      mqb_d;

    // MEM/WB pipeline register
    logic        wwreg_q,    wwreg_d;
    logic        wm2reg_q,   wm2reg_d;
    logic [4:0]  wdest_q,    wdest_d;
    logic [31:0] walu_q,     walu_d;
    logic [31:0] wmdo_q,     wmdo_d;

    logic [31:0]        alu_b;
    logic [DMEM_AW-1:0] mem_addr;
    logic [31:0]        mdo;
    logic [31:0]        dmem_q [DMEM_DEPTH];

    // The byte offset and the address bits above the memory wrap are
    // deliberately ignored; this collapses them so they read as consumed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^malu_q;

    // EXE: operand select and ALU
    always_comb begin
        alu_b = ealuimm ? eimm32 : eqb;
        ealu  = 32'h0;
        case (ealuc)
            ALU_AND: ealu = eqa & alu_b;
            ALU_OR:  ealu = eqa | alu_b;
            ALU_ADD: ealu = eqa + alu_b;
            ALU_SUB: ealu = eqa - alu_b;
            ALU_SLT: ealu = ($signed(eqa) < $signed(alu_b)) ? 32'h1 : 32'h0;
            ALU_NOR: ealu = ~(eqa | alu_b);
            default: ealu = 32'h0;
        endcase
    end

    // Next state of the EXE/MEM register: capture the EXE stage as-is
    always_comb begin
        mwreg_d  = ewreg;
        mm2reg_d = em2reg;
        mwmem_d  = ewmem;
        mdest_d  = edestReg;
        malu_d   = ealu;
        mqb_d    = eqb;
    end

    // EXE/MEM register update; reset turns every in-flight slot into a bubble
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mwreg_q  <= 1'b0;
            mm2reg_q <= 1'b0;
            mwmem_q  <= 1'b0;
            mdest_q  <= 5'd0;
            malu_q   <= 32'h0;
            mqb_q    <= 32'h0;
        end else begin
            mwreg_q  <= mwreg_d;
            mm2reg_q <= mm2reg_d;
            mwmem_q  <= mwmem_d;
            mdest_q  <= mdest_d;
            malu_q   <= malu_d;
            mqb_q    <= mqb_d;
        end
    end

    // MEM: word address wraps modulo the memory depth; read is asynchronous
    always_comb begin
        mem_addr = malu_q[DMEM_AW+1:2];
        mdo      = dmem_q[mem_addr];
    end

    // Data memory write; contents survive reset, and the resetn gate keeps a
    // store from landing on the clock edge where reset is still low
    always_ff @(posedge clk) begin
        if (resetn && mwmem_q) begin
            dmem_q[mem_addr] <= mqb_q;
        end
    end

    // Next state of the MEM/WB register; r0 is hard-wired so never written
    always_comb begin
        wwreg_d  = mwreg_q & (mdest_q != 5'd0);
        wm2reg_d = mm2reg_q;
        wdest_d  = mdest_q;
        walu_d   = malu_q;
        wmdo_d   = mdo;
    end

    // MEM/WB register update
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wwreg_q  <= 1'b0;
            wm2reg_q <= 1'b0;
            wdest_q  <= 5'd0;
            walu_q   <= 32'h0;
            wmdo_q   <= 32'h0;
        end else begin
            wwreg_q  <= wwreg_d;
            wm2reg_q <= wm2reg_d;
            wdest_q  <= wdest_d;
            walu_q   <= walu_d;
            wmdo_q   <= wmdo_d;
        end
    end

    // Output taps and WB data select
    always_comb begin
        mwreg    = mwreg_q;
        mm2reg   = mm2reg_q;
        mdestReg = mdest_q;
        malu     = malu_q;
        wwreg    = wwreg_q;
        wdestReg = wdest_q;
        wbData   = wm2reg_q ? wmdo_q : walu_q;
    end

endmodule

// File: tb/tb_exe_mem_wb_backend.sv
// Self-checking bench for exe_mem_wb_backend: hand-computed vector table,
// directed multi-cycle corner cases, and random traffic against an
// instruction-at-a-time reference model.
module tb_exe_mem_wb_backend;

    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ewreg, em2reg, ewmem, ealuimm;
    logic [3:0]  ealuc;
    logic [4:0]  edestReg;
    logic [31:0] eqa, eqb, eimm32;
    logic [31:0] ealu, malu, wbData;
    logic        mwreg, mm2reg, wwreg;
    logic [4:0]  mdestReg, wdestReg;

    exe_mem_wb_backend #(.DMEM_AW(AW)) dut (
        .clk(clk), .resetn(resetn),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ealuimm(ealuimm),
        .ealuc(ealuc), .edestReg(edestReg),
        .eqa(eqa), .eqb(eqb), .eimm32(eimm32),
        .ealu(ealu), .mwreg(mwreg), .mm2reg(mm2reg), .mdestReg(mdestReg),
        .malu(malu), .wwreg(wwreg), .wdestReg(wdestReg), .wbData(wbData)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        wreg, m2reg, wmem, aluimm;
        bit [3:0]  aluc;
        bit [4:0]  dest;
        bit [31:0] qa, qb, imm;
    } instr_t;

    typedef struct {
        bit [31:0] alu;
        bit [31:0] wb;
        bit        wen;
        bit [4:0]  dest;
        bit        mwreg, mm2reg;
    } exp_t;

    typedef struct {
        instr_t    in;
        bit [31:0] exp;
    } vec_t;

    int errors = 0;
    int checks = 0;

    bit [31:0] mdl_mem [DEPTH];
    exp_t      prev;
    exp_t      zero_exp;
    instr_t    bubble;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] ref_alu(input instr_t x);
        bit [31:0] b;
        b = x.aluimm ? x.imm : x.qb;
        case (x.aluc)
            4'd0:  return x.qa & b;
            4'd1:  return x.qa | b;
            4'd2:  return x.qa + b;
            4'd6:  return x.qa - b;
            4'd7:  return ($signed(x.qa) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12: return ~(x.qa | b);
            default: return 32'd0;
        endcase
    endfunction

    // Executes one instruction to completion in program order
    task automatic model_exec(input instr_t x, output exp_t e);
        int idx;
        bit [31:0] ld;
        e.alu    = ref_alu(x);
        idx      = int'(e.alu / 4) % DEPTH;
        ld       = mdl_mem[idx];
        if (x.wmem) mdl_mem[idx] = x.qb;
        e.wb     = x.m2reg ? ld : e.alu;
        e.wen    = x.wreg && (x.dest != 0);
        e.dest   = x.dest;
        e.mwreg  = x.wreg;
        e.mm2reg = x.m2reg;
    endtask

    task automatic drive(input instr_t x);
        ewreg = x.wreg; em2reg = x.m2reg; ewmem = x.wmem; ealuimm = x.aluimm;
        ealuc = x.aluc; edestReg = x.dest;
        eqa = x.qa; eqb = x.qb; eimm32 = x.imm;
    endtask

    // Issue one instruction; check EXE, M-stage and WB taps
    task automatic step(input instr_t x);
        exp_t e;
        drive(x);
        model_exec(x, e);
        #1;
        chk("ealu", ealu, e.alu);
        @(posedge clk);
        #1;
        chk("malu", malu, e.alu);
        chk("mwreg", mwreg, e.mwreg);
        chk("mm2reg", mm2reg, e.mm2reg);
        chk("mdestReg", mdestReg, e.dest);
        chk("wwreg", wwreg, prev.wen);
        chk("wdestReg", wdestReg, prev.dest);
        chk("wbData", wbData, prev.wb);
        prev = e;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wwreg"}, wwreg, 0);
        chk({tag, "_wdest"}, wdestReg, 0);
        chk({tag, "_wbData"}, wbData, 0);
        chk({tag, "_mwreg"}, mwreg, 0);
        chk({tag, "_mm2reg"}, mm2reg, 0);
        chk({tag, "_mdest"}, mdestReg, 0);
        chk({tag, "_malu"}, malu, 0);
    endtask

    function automatic instr_t mk(input bit wreg, input bit m2reg, input bit wmem,
                                  input bit aluimm, input bit [3:0] aluc,
                                  input bit [4:0] dest, input bit [31:0] qa,
                                  input bit [31:0] qb, input bit [31:0] imm);
        instr_t x;
        x.wreg = wreg; x.m2reg = m2reg; x.wmem = wmem; x.aluimm = aluimm;
        x.aluc = aluc; x.dest = dest; x.qa = qa; x.qb = qb; x.imm = imm;
        return x;
    endfunction

    vec_t tbl [10];

    initial begin
        instr_t x;
        int     kind;
        bit [3:0] codes [7];

        zero_exp = '{default: 0};
        bubble   = '{default: 0};
        prev     = zero_exp;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 0;
        codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd15};

        tbl[0] = '{mk(1, 0, 0, 0, 4'b0010, 5'd1, 32'hFFFFFFFF, 32'h1, 32'h0), 32'h00000000};
        tbl[1] = '{mk(1, 0, 0, 0, 4'b0110, 5'd2, 32'hFFFFFFFF, 32'h1, 32'h0), 32'hFFFFFFFE};
        tbl[2] = '{mk(1, 0, 0, 0, 4'b0111, 5'd3, 32'hFFFFFFFF, 32'h1, 32'h0), 32'h00000001};
        tbl[3] = '{mk(1, 0, 0, 0, 4'b1100, 5'd4, 32'hFFFFFFFF, 32'h1, 32'h0), 32'h00000000};
        tbl[4] = '{mk(1, 0, 0, 0, 4'b1111, 5'd5, 32'hFFFFFFFF, 32'h1, 32'h0), 32'h00000000};
        tbl[5] = '{mk(1, 0, 0, 0, 4'b0000, 5'd6, 32'hFFFFFFFF, 32'h1, 32'h0), 32'h00000001};
        tbl[6] = '{mk(1, 0, 0, 0, 4'b0001, 5'd7, 32'hFFFFFFFF, 32'h1, 32'h0), 32'hFFFFFFFF};
        tbl[7] = '{mk(1, 0, 0, 1, 4'b0010, 5'd9, 32'h8, 32'h123, 32'hFFFFFFFC), 32'h00000004};
        tbl[8] = '{mk(1, 0, 0, 0, 4'b0011, 5'd10, 32'h5, 32'h3, 32'h0), 32'h00000000};
        tbl[9] = '{mk(1, 0, 0, 0, 4'b0111, 5'd11, 32'h1, 32'hFFFFFFFF, 32'h0), 32'h00000000};

        // Reset with garbage inputs held across 3 posedges
        resetn = 1'b0;
        drive(mk(1, 1, 1, 1, 4'b0010, 5'd17, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h12345678));
        #2;
        check_all_zero("rst0");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_wwreg", wwreg, 0);
            chk("rst_wbData", wbData, 0);
            chk("rst_malu", malu, 0);
        end
        resetn = 1'b1;

        // Load of word 0 after reset reads power-up zero
        step(mk(1, 1, 0, 1, 4'b0010, 5'd3, 32'h0, 32'h0, 32'h0));
        step(bubble);
        chk("rst_load0", wbData, 32'h0);
        chk("rst_load0_wen", wwreg, 1);

        // Hand-computed ALU/immediate table
        foreach (tbl[i]) begin
            step(tbl[i].in);
            chk("tbl_malu", malu, tbl[i].exp);
            step(bubble);
            chk("tbl_wb", wbData, tbl[i].exp);
            chk("tbl_wdest", wdestReg, tbl[i].in.dest);
            chk("tbl_wen", wwreg, 1);
        end

        // Store then back-to-back load of the same word
        step(mk(0, 0, 1, 1, 4'b0010, 5'd0, 32'h0, 32'hDEADBEEF, 32'd12));
        step(mk(1, 1, 0, 1, 4'b0010, 5'd5, 32'h0, 32'h0, 32'd12));
        step(bubble);
        chk("sl_wb", wbData, 32'hDEADBEEF);
        chk("sl_dest", wdestReg, 5);
        chk("sl_wen", wwreg, 1);
        step(mk(1, 1, 0, 1, 4'b0010, 5'd8, 32'h0, 32'h0, 32'd12 + 32'(4 * DEPTH)));
        step(bubble);
        chk("wrap_wb", wbData, 32'hDEADBEEF);

        // r0 guard
        step(mk(1, 0, 0, 0, 4'b0001, 5'd0, 32'h7, 32'h0, 32'h0));
        step(bubble);
        chk("r0_wen", wwreg, 0);
        chk("r0_wb", wbData, 32'h7);

        // Reset mid-flight: lw in MEM when reset hits
        step(mk(1, 1, 0, 1, 4'b0010, 5'd6, 32'h0, 32'h0, 32'd12));
        resetn = 1'b0;
        #1;
        check_all_zero("midrst");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_wwreg", wwreg, 0);
        end
        resetn = 1'b1;
        prev = zero_exp;
        step(bubble);
        chk("midrst_after_wen", wwreg, 0);

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 4);
            x = bubble;
            x.dest = 5'($urandom_range(0, 31));
            case (kind)
                0, 1: begin
                    x.wreg   = 1'($urandom_range(0, 1));
                    x.aluimm = (kind == 1);
                    x.aluc   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 6)];
                    x.qa     = $urandom;
                    x.qb     = $urandom;
                    x.imm    = $urandom;
                end
                2: begin
                    x.wreg = 1'b1; x.m2reg = 1'b1; x.aluimm = 1'b1; x.aluc = 4'b0010;
                    x.qa = $urandom & 32'h1FF; x.imm = $urandom_range(0, 255);
                end
                3: begin
                    x.wmem = 1'b1; x.aluimm = 1'b1; x.aluc = 4'b0010;
                    x.qa = $urandom & 32'h1FF; x.imm = $urandom_range(0, 255);
                    x.qb = $urandom;
                end
                default: x = bubble;
            endcase
            step(x);
        end
        step(bubble);
        step(bubble);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
